// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and byte-lane helpers for the MEM stage
package mem_stage_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10,
      RSVD = 2'b11
   } mem_size_t;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   function automatic logic [3:0] byte_enable(input mem_size_t size, input logic [1:0] addr_lo);
      case (size)
         BYTE:    byte_enable = 4'b0001 << addr_lo;
         HALF:    byte_enable = addr_lo[1] ? 4'b1100 : 4'b0011;
         WORD:    byte_enable = 4'b1111;
         default: byte_enable = 4'b0000;
      endcase
   endfunction

   // Reserved size is always treated as misaligned so it never reaches the bus.
   function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
      case (size)
         BYTE:    is_misaligned = 1'b0;
         HALF:    is_misaligned = addr_lo[0];
         WORD:    is_misaligned = (addr_lo != 2'b00);
         default: is_misaligned = 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] lane_replicate(input mem_size_t size, input logic [31:0] data);
      case (size)
         BYTE:    lane_replicate = {4{data[7:0]}};
         HALF:    lane_replicate = {2{data[15:0]}};
         default: lane_replicate = data;
      endcase
   endfunction

endpackage

// File: rtl/load_formatter.sv
// rtl/load_formatter.sv - little-endian lane select and sign/zero extension of load data
module load_formatter
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  mem_size_t   size,
   input  logic        unsignedLoad,
   output logic [31:0] data
);

   logic [7:0]  byteLane;
   logic [15:0] halfLane;

   always_comb begin
      case (addr_lo)
         2'd0:    byteLane = rdata[7:0];
         2'd1:    byteLane = rdata[15:8];
         2'd2:    byteLane = rdata[23:16];
         default: byteLane = rdata[31:24];
      endcase
      halfLane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      case (size)
         BYTE:    data = {{24{byteLane[7] & ~unsignedLoad}}, byteLane};
         HALF:    data = {{16{halfLane[15] & ~unsignedLoad}}, halfLane};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage with req/ack data-memory port and timeout
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 16
)
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           alu_result,
   input  logic [31:0]           store_data,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [1:0]            mem_size,
   input  logic                  load_unsigned,
   input  logic [4:0]            dest_reg,
   input  logic                  reg_write,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [3:0]            dmem_be,
   output logic [31:0]           dmem_wdata,
   input  logic                  dmem_ack,
   input  logic [31:0]           dmem_rdata,
   output logic                  out_valid,
   output logic [31:0]           out_data,
   output logic [4:0]            out_dest_reg,
   output logic                  out_reg_write,
   output logic                  misaligned,
   output logic                  bus_error
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

   mem_state_t state, nextState;

   logic                  accept;
   logic                  isMemOp;
   logic                  badAlign;
   logic                  startReq;
   logic                  timeoutHit;
   logic [CNT_W-1:0]      waitCount;
   logic [ADDR_WIDTH+1:0] reqAddr;
   logic                  reqWe;
   logic                  reqIsLoad;
   logic                  reqUnsigned;
   logic                  reqRegWrite;
   logic [4:0]            reqDest;
   mem_size_t             reqSize;
   logic [3:0]            reqBe;
   logic [31:0]           reqWdata;
   logic [31:0]           loadData;

   assign accept     = in_valid && in_ready;
   assign isMemOp    = mem_read || mem_write;
   assign badAlign   = is_misaligned(mem_size_t'(mem_size), alu_result[1:0]);
   assign startReq   = accept && isMemOp && !badAlign;
   assign timeoutHit = (waitCount == LAST_WAIT);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (startReq) nextState = WAIT;
         WAIT:    if (dmem_ack || timeoutHit) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == IDLE);
      dmem_req = (state == WAIT);
      dmem_we  = (state == WAIT) && reqWe;
   end

   // Request fields are captured once so the bus stays stable for the whole WAIT.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         reqAddr     <= '0;
         reqWe       <= 1'b0;
         reqIsLoad   <= 1'b0;
         reqUnsigned <= 1'b0;
         reqRegWrite <= 1'b0;
         reqDest     <= '0;
         reqSize     <= BYTE;
         reqBe       <= '0;
         reqWdata    <= '0;
      end else if (startReq) begin
         reqAddr     <= alu_result[ADDR_WIDTH+1:0];
         reqWe       <= mem_write;
         reqIsLoad   <= mem_read && !mem_write;
         reqUnsigned <= load_unsigned;
         reqRegWrite <= reg_write;
         reqDest     <= dest_reg;
         reqSize     <= mem_size_t'(mem_size);
         reqBe       <= byte_enable(mem_size_t'(mem_size), alu_result[1:0]);
         reqWdata    <= lane_replicate(mem_size_t'(mem_size), store_data);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                waitCount <= '0;
      else if (state == IDLE)    waitCount <= '0;
      else if (!dmem_ack)        waitCount <= waitCount + CNT_W'(1);
   end

   assign dmem_addr  = reqAddr[ADDR_WIDTH+1:2];
   assign dmem_be    = reqBe;
   assign dmem_wdata = reqWdata;

   load_formatter u_load_formatter (
      .rdata        (dmem_rdata),
      .addr_lo      (reqAddr[1:0]),
      .size         (reqSize),
      .unsignedLoad (reqUnsigned),
      .data         (loadData)
   );

   // MEM/WB register; the three pulses are exclusive because each arm sets at most one.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_dest_reg  <= '0;
         out_reg_write <= 1'b0;
         misaligned    <= 1'b0;
         bus_error     <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         misaligned <= 1'b0;
         bus_error  <= 1'b0;
         if (accept) begin
            if (!isMemOp) begin
               out_valid     <= 1'b1;
               out_data      <= alu_result;
               out_dest_reg  <= dest_reg;
               out_reg_write <= reg_write;
            end else if (badAlign) begin
               misaligned <= 1'b1;
            end
         end else if (state == WAIT) begin
            if (dmem_ack) begin
               out_valid     <= 1'b1;
               out_dest_reg  <= reqDest;
               out_data      <= reqIsLoad ? loadData : 32'h0;
               out_reg_write <= reqIsLoad && reqRegWrite;
            end else if (timeoutHit) begin
               bus_error <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized self-checking bench for mem_access_stage
module tb_mem_access_stage;

   localparam int AW = 8;
   localparam int TO = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   alu_result;
   logic [31:0]   store_data;
   logic          mem_read;
   logic          mem_write;
   logic [1:0]    mem_size;
   logic          load_unsigned;
   logic [4:0]    dest_reg;
   logic          reg_write;
   logic          dmem_req;
   logic          dmem_we;
   logic [AW-1:0] dmem_addr;
   logic [3:0]    dmem_be;
   logic [31:0]   dmem_wdata;
   logic          dmem_ack;
   logic [31:0]   dmem_rdata;
   logic          out_valid;
   logic [31:0]   out_data;
   logic [4:0]    out_dest_reg;
   logic          out_reg_write;
   logic          misaligned;
   logic          bus_error;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mem_access_stage #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clock         (clock),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .alu_result    (alu_result),
      .store_data    (store_data),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_size      (mem_size),
      .load_unsigned (load_unsigned),
      .dest_reg      (dest_reg),
      .reg_write     (reg_write),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_be       (dmem_be),
      .dmem_wdata    (dmem_wdata),
      .dmem_ack      (dmem_ack),
      .dmem_rdata    (dmem_rdata),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_dest_reg  (out_dest_reg),
      .out_reg_write (out_reg_write),
      .misaligned    (misaligned),
      .bus_error     (bus_error)
   );

   function automatic int size_bytes(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit ref_misaligned(input logic [1:0] s, input logic [31:0] a);
      if (s == 2'd3) return 1'b1;
      return (int'(a[1:0]) % size_bytes(s)) != 0;
   endfunction

   function automatic logic [3:0] ref_be(input logic [1:0] s, input logic [31:0] a);
      int nb;
      int off;
      nb  = size_bytes(s);
      off = int'(a[1:0]);
      return 4'(((1 << nb) - 1) << off);
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [1:0] s, input logic [31:0] d);
      longint v;
      int nb;
      nb = size_bytes(s);
      v  = longint'(d) & ((64'sd1 << (8 * nb)) - 1);
      if (nb == 1) return 32'(v * 64'sh01010101);
      if (nb == 2) return 32'(v * 64'sh00010001);
      return d;
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] s, input logic [31:0] a,
                                            input logic [31:0] rd, input bit uns);
      longint v;
      int bits;
      int off;
      bits = 8 * size_bytes(s);
      off  = 8 * int'(a[1:0]);
      v    = (longint'(rd) >> off) & ((64'sd1 << bits) - 1);
      if (!uns && v >= (64'sd1 << (bits - 1))) v = v - (64'sd1 << bits);
      return 32'(v);
   endfunction

   // Issues one operation from IDLE and follows it to its result; ackDelay >= TO means no ack.
   task automatic do_op(input string tag, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rdata, input bit rd, input bit wr,
                        input logic [1:0] size, input bit uns, input logic [4:0] dest,
                        input bit rw, input int ackDelay);
      bit          isMem;
      bit          isLoad;
      int          expCycles;
      logic [31:0] expData;
      isMem     = rd || wr;
      isLoad    = rd && !wr;
      expCycles = (ackDelay < TO) ? ackDelay + 1 : TO;
      expData   = isLoad ? ref_load(size, addr, rdata, uns) : 32'h0;

      checks++;
      if (in_ready !== 1'b1)
         $display("FAIL %s accept_ready: in_ready=%b required 1", tag, in_ready);
      in_valid      = 1'b1;
      alu_result    = addr;
      store_data    = data;
      mem_read      = rd;
      mem_write     = wr;
      mem_size      = size;
      load_unsigned = uns;
      dest_reg      = dest;
      reg_write     = rw;
      dmem_ack      = 1'($urandom);
      @(posedge clock); #1;
      in_valid      = 1'b0;
      dmem_ack      = 1'b0;
      alu_result    = $urandom;
      store_data    = $urandom;
      mem_size      = 2'($urandom);
      load_unsigned = 1'($urandom);
      dest_reg      = 5'($urandom);
      reg_write     = 1'($urandom);

      if (!isMem) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== addr || out_dest_reg !== dest ||
             out_reg_write !== rw || misaligned !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s passthru: valid=%b data=%h dest=%0d rw=%b mis=%b req=%b required 1 %h %0d %b 0 0",
                     tag, out_valid, out_data, out_dest_reg, out_reg_write, misaligned, dmem_req,
                     addr, dest, rw);
         end
         return;
      end

      if (ref_misaligned(size, addr)) begin
         checks++;
         if (misaligned !== 1'b1 || out_valid !== 1'b0 || bus_error !== 1'b0 ||
             dmem_req !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s misaligned: mis=%b valid=%b berr=%b req=%b ready=%b required 1 0 0 0 1",
                     tag, misaligned, out_valid, bus_error, dmem_req, in_ready);
         end
         @(posedge clock); #1;
         checks++;
         if (misaligned !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s misaligned_pulse: mis=%b req=%b required 0 0", tag, misaligned, dmem_req);
         end
         return;
      end

      for (int k = 0; k < expCycles; k++) begin
         checks++;
         if (dmem_req !== 1'b1 || in_ready !== 1'b0 || dmem_we !== wr ||
             dmem_addr !== addr[AW+1:2] || dmem_be !== ref_be(size, addr) ||
             (wr && dmem_wdata !== ref_wdata(size, data)) ||
             out_valid !== 1'b0 || bus_error !== 1'b0 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL %s wait_cycle%0d: req=%b ready=%b we=%b addr=%h be=%b wdata=%h valid=%b berr=%b required 1 0 %b %h %b %h 0 0",
                     tag, k, dmem_req, in_ready, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                     out_valid, bus_error, wr, addr[AW+1:2], ref_be(size, addr),
                     ref_wdata(size, data));
         end
         if (k == ackDelay) begin
            dmem_ack   = 1'b1;
            dmem_rdata = rdata;
         end
         @(posedge clock); #1;
         dmem_ack   = 1'b0;
         dmem_rdata = $urandom;
      end

      checks++;
      if (dmem_req !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s release: req=%b ready=%b required 0 1", tag, dmem_req, in_ready);
      end
      checks++;
      if (ackDelay < TO) begin
         if (out_valid !== 1'b1 || bus_error !== 1'b0 || out_data !== expData ||
             out_reg_write !== (isLoad && rw) || (isLoad && out_dest_reg !== dest)) begin
            errors++;
            $display("FAIL %s result: valid=%b berr=%b data=%h rw=%b dest=%0d required 1 0 %h %b %0d",
                     tag, out_valid, bus_error, out_data, out_reg_write, out_dest_reg,
                     expData, isLoad && rw, dest);
         end
      end else begin
         if (bus_error !== 1'b1 || out_valid !== 1'b0 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL %s timeout: berr=%b valid=%b mis=%b required 1 0 0",
                     tag, bus_error, out_valid, misaligned);
         end
      end
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b0 || bus_error !== 1'b0 || misaligned !== 1'b0) begin
         errors++;
         $display("FAIL %s pulse_end: valid=%b berr=%b mis=%b required 0 0 0",
                  tag, out_valid, bus_error, misaligned);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b0; alu_result = '0; store_data = '0; mem_read = 1'b0;
      mem_write = 1'b0; mem_size = 2'd0; load_unsigned = 1'b0; dest_reg = '0; reg_write = 1'b0;
      dmem_ack = 1'b0; dmem_rdata = '0;
      #2;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_dest_reg !== 5'd0 || out_reg_write !== 1'b0 ||
          misaligned !== 1'b0 || bus_error !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 ||
          dmem_addr !== '0 || dmem_be !== 4'h0 || dmem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b data=%h req=%b we=%b addr=%h be=%b wdata=%h required all zero",
                  out_valid, out_data, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
      end
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (in_ready !== 1'b1 || dmem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: ready=%b req=%b required 1 0", in_ready, dmem_req);
      end
   endtask

   task automatic test_word_store();
      do_op("word_store", 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd5, 1'b1, 3);
   endtask

   task automatic test_byte_load();
      do_op("byte_load_s", 32'h13, 32'h0, 32'h80FFFFFF, 1'b1, 1'b0, 2'd0, 1'b0, 5'd7, 1'b1, 0);
      do_op("byte_load_u", 32'h13, 32'h0, 32'h80FFFFFF, 1'b1, 1'b0, 2'd0, 1'b1, 5'd8, 1'b1, 0);
   endtask

   task automatic test_half();
      do_op("half_store", 32'h06, 32'h1234ABCD, 32'h0, 1'b0, 1'b1, 2'd1, 1'b0, 5'd2, 1'b0, 1);
      do_op("half_load_mis", 32'h05, 32'h0, 32'h0, 1'b1, 1'b0, 2'd1, 1'b0, 5'd3, 1'b1, 0);
      do_op("rsvd_size", 32'h08, 32'h0, 32'h0, 1'b1, 1'b0, 2'd3, 1'b0, 5'd3, 1'b1, 0);
      do_op("both_rw", 32'h0C, 32'h55AA55AA, 32'hFFFFFFFF, 1'b1, 1'b1, 2'd2, 1'b0, 5'd9, 1'b1, 2);
   endtask

   task automatic test_back_to_back();
      logic [31:0] prevData;
      logic [4:0]  prevDest;
      logic        prevRw;
      prevData = '0; prevDest = '0; prevRw = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prevData || out_dest_reg !== prevDest ||
                out_reg_write !== prevRw || in_ready !== 1'b1) begin
               errors++;
               $display("FAIL b2b_%0d: valid=%b data=%h dest=%0d rw=%b ready=%b required 1 %h %0d %b 1",
                        i, out_valid, out_data, out_dest_reg, out_reg_write, in_ready,
                        prevData, prevDest, prevRw);
            end
         end
         in_valid   = 1'b1;
         alu_result = (i < 3) ? 32'(i + 1) : $urandom;
         dest_reg   = 5'($urandom);
         reg_write  = 1'($urandom);
         prevData   = alu_result;
         prevDest   = dest_reg;
         prevRw     = reg_write;
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== prevData) begin
         errors++;
         $display("FAIL b2b_last: valid=%b data=%h required 1 %h", out_valid, out_data, prevData);
      end
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_timeout();
      do_op("timeout", 32'h40, 32'h0, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd4, 1'b1, TO + 4);
      do_op("ack_at_limit", 32'h44, 32'h0, 32'h00C0FFEE, 1'b1, 1'b0, 2'd2, 1'b0, 5'd6, 1'b1, TO - 1);
   endtask

   task automatic test_reset_mid_wait();
      in_valid = 1'b1; alu_result = 32'h20; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'd2;
      @(posedge clock); #1;
      in_valid = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (dmem_req !== 1'b1) begin
         errors++;
         $display("FAIL rst_wait_pre: req=%b required 1", dmem_req);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (dmem_req !== 1'b0 || out_valid !== 1'b0 || bus_error !== 1'b0 || misaligned !== 1'b0) begin
         errors++;
         $display("FAIL rst_wait_drop: req=%b valid=%b berr=%b mis=%b required 0 0 0 0",
                  dmem_req, out_valid, bus_error, misaligned);
      end
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (dmem_req !== 1'b0 || out_valid !== 1'b0 || bus_error !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_wait_after: req=%b valid=%b berr=%b ready=%b required 0 0 0 1",
                  dmem_req, out_valid, bus_error, in_ready);
      end
      do_op("rst_wait_load", 32'h22, 32'h0, 32'hBEEF8001, 1'b1, 1'b0, 2'd1, 1'b0, 5'd11, 1'b1, 1);
   endtask

   task automatic test_random();
      logic [1:0] kind;
      int         delay;
      for (int i = 0; i < 60; i++) begin
         kind  = 2'($urandom);
         delay = ($urandom_range(0, 9) == 0) ? TO + 2 : int'($urandom_range(0, 4));
         do_op($sformatf("rand_%0d", i), $urandom, $urandom, $urandom,
               kind[0], kind[1], 2'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), delay);
      end
   endtask

   initial begin
      test_reset();
      test_word_store();
      test_byte_load();
      test_half();
      test_back_to_back();
      test_timeout();
      test_reset_mid_wait();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised MEM pipeline stage for the MIPS core: accepts one EX/MEM operation at a time, drives a request/acknowledge data-memory port with byte/halfword/word access, formats load data with sign or zero extension, and registers the result into the MEM/WB boundary. It replaces the fixed single-cycle word-only memory hookup. Multi-cycle memories stall EX through `in_ready`, and a timeout guards against a memory that never acknowledges.

## Interface
- `ADDR_WIDTH`, 8: word-address bits driven to memory. Byte address bits used are `[ADDR_WIDTH+1:0]`.
- `TIMEOUT_CYCLES`, 16: maximum cycles spent in WAIT before an abort. Must be ≥1.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `in_valid` in 1 / `in_ready` out 1: EX→MEM handshake. An operation is accepted when both are high on a clock edge.
- `alu_result` in 32: byte address, or pass-through value for non-memory ops.
- `store_data` in 32: rt value to store.
- `mem_read`, `mem_write` in 1 each.
- `mem_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `load_unsigned` in 1: zero-extend when 1, sign-extend when 0.
- `dest_reg` in 5, `reg_write` in 1: writeback tag.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out ADDR_WIDTH, `dmem_be` out 4, `dmem_wdata` out 32.
- `dmem_ack` in 1, `dmem_rdata` in 32.
- `out_valid` out 1, `out_data` out 32, `out_dest_reg` out 5, `out_reg_write` out 1: MEM/WB register.
- `misaligned` out 1, `bus_error` out 1: one-cycle exception pulses.

## Operation
- FSM states: IDLE, WAIT. `in_ready` = (state == IDLE).
- Accept in IDLE:
  - Non-memory op (`mem_read` = `mem_write` = 0): next cycle `out_valid`=1, `out_data`=`alu_result`, tag passed through. State stays IDLE.
  - Memory op, aligned: register all fields and go to WAIT.
  - Memory op, misaligned (half with `addr[0]`=1, word with `addr[1:0]`≠0, or size 11): next cycle `misaligned`=1, `out_valid`=0, no memory request. State stays IDLE.
- Both `mem_read` and `mem_write` set: treated as a store only, with no load writeback.
- WAIT:
  - `dmem_req`=1 with all `dmem_*` held stable until ack. `dmem_we`=`mem_write`. `dmem_addr`=`alu_result[ADDR_WIDTH+1:2]`.
  - On `dmem_ack`: go to IDLE. Next cycle `out_valid`=1.
    - Load: `out_data` = formatted `dmem_rdata`, `out_reg_write`=`reg_write`.
    - Store: `out_data`=0, `out_reg_write`=0.
- Byte lanes are little-endian.
  - Byte at offset n: `be`=1<<n, wdata = byte replicated ×4.
  - Half: `be`=0011 (`addr[1]`=0) or 1100, wdata = half replicated ×2.
  - Word: `be`=1111.
- Load format: select lane by `addr[1:0]` / `addr[1]`, then extend to 32 bits per `load_unsigned`.
- Timeout:
  - Counter cleared on entry to WAIT, increments each WAIT cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`: drop the request, pulse `bus_error` next cycle with `out_valid`=0, return to IDLE.
  - Ack in the same cycle as the limit: ack wins.

## Timing
- Reset (asynchronous, immediate): state IDLE, counter 0, all outputs 0, `in_ready`=1 after deassertion.
- Reset during WAIT drops `dmem_req` at once. No output or exception is produced.
- Latency:
  - Non-memory op: 1 cycle, throughput 1 per cycle.
  - Memory op: `dmem_req` rises the cycle after acceptance. Ack is sampled at the earliest in that same cycle, so minimum accept-to-`out_valid` is 2 cycles.
- `out_valid`, `misaligned`, `bus_error` are single-cycle pulses, mutually exclusive. WB never back-pressures.
- `dmem_ack` outside WAIT is ignored.

## Structure
- `mem_stage_pkg`:
  - enum `mem_size_t` (BYTE, HALF, WORD, RSVD).
  - enum `mem_state_t` (IDLE, WAIT).
  - function `byte_enable(size, addr_lo)`.
- Sub-module `load_formatter`: combinational lane select and extension. Inputs: `rdata`, `addr_lo[1:0]`, `size`, `unsigned`. Output: 32-bit data.
- Top holds the FSM, request registers, timeout counter and MEM/WB register.

## Test plan
- Word store to byte address 0x10, data 0xDEADBEEF, ack after 3 cycles → `dmem_addr`=4, `be`=1111, `in_ready` low 4 cycles, `out_valid` with `out_reg_write`=0.
- Signed byte load at 0x13 with rdata 0x80FFFFFF, ack the same cycle as req → `be`=1000, `out_data`=0xFFFFFF80. The unsigned variant gives 0x00000080.
- Half store at 0x06, data 0x1234ABCD → `be`=1100, `wdata`=0xABCDABCD. Half load at 0x05 → `misaligned` pulse, no `dmem_req`.
- Back-to-back non-memory ops with `alu_result` 1, 2, 3 → `out_data` 1, 2, 3 on consecutive cycles.
- No ack with `TIMEOUT_CYCLES`=16 → `dmem_req` high 16 cycles, then a `bus_error` pulse and `in_ready`=1.
- `reset` asserted mid-WAIT → `dmem_req`=0 immediately. After release, a new load completes normally.
